// File: rtl/ctrl_seq_pkg.sv
// ctrl_seq_pkg: shared constants for the control sequencer.
//   state_t      - sequencer states
//   OP_*         - opcode map decoded in DECODE
//   ALU_*        - alu_op encodings driven during MEMRD
//   FAULT_*      - bit positions in the sticky fault vector
package ctrl_seq_pkg;

   localparam int WORD_LENGTH = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_MEMRD,
      S_MEMWR,
      S_HALT
   } state_t;

   localparam int OP_NOP   = 0;
   localparam int OP_LOAD  = 1;
   localparam int OP_ADD   = 2;
   localparam int OP_SUB   = 3;
   localparam int OP_STORE = 4;
   localparam int OP_JMP   = 5;
   localparam int OP_JZ    = 6;
   localparam int OP_HALT  = 7;

   localparam logic [1:0] ALU_PASS = 2'b00;
   localparam logic [1:0] ALU_ADD  = 2'b01;
   localparam logic [1:0] ALU_SUB  = 2'b10;

   localparam int FAULT_ILL = 0;
   localparam int FAULT_TMO = 1;

endpackage

// File: rtl/ctrl_seq_wait_timer.sv
// wait_timer: cycle counter bounding a memory handshake.
//   clk, rst   - clock / async active-high reset
//   i_clear    - zero the counter (wins over i_count)
//   i_count    - advance the counter by one
//   i_limit    - timeout length in cycles
//   o_expired  - counter sits at i_limit-1 (last allowed wait cycle)
module wait_timer #(
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_clear,
   input  logic          i_count,
   input  logic [CW-1:0] i_limit,
   output logic          o_expired
);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)          r_cnt <= '0;
      else if (i_clear) r_cnt <= '0;
      else if (i_count) r_cnt <= r_cnt + 1'b1;
   end

   assign o_expired = (r_cnt == i_limit - 1'b1);

endmodule

// File: rtl/ctrl_seq.sv
// ctrl_seq: multi-cycle control sequencer for the CPU datapath.
//   clk, rst            - clock / async active-high reset
//   i_opcode            - IR opcode field (sampled in DECODE, held through MEMRD)
//   i_zero              - ACC zero flag for JZ
//   i_mem_ready         - one-cycle memory completion pulse
//   o_mem_rd, o_mem_wr  - memory request (mutually exclusive)
//   o_addr_sel          - 0 = PC address, 1 = IR operand address
//   o_ir_en, o_pc_en, o_acc_en - single-cycle register load strobes
//   o_pc_sel            - 0 = PC+1, 1 = branch target
//   o_alu_op            - 00 pass, 01 add, 10 sub
//   o_halted            - sequencer stopped
//   o_fault             - sticky {timeout, illegal opcode}
module ctrl_seq
   import ctrl_seq_pkg::*;
#(
   parameter int OPW     = 4,
   parameter int TIMEOUT = 16,
   parameter int CW      = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [OPW-1:0] i_opcode,
   input  logic           i_zero,
   input  logic           i_mem_ready,
   output logic           o_mem_rd,
   output logic           o_mem_wr,
   output logic           o_addr_sel,
   output logic           o_ir_en,
   output logic           o_pc_en,
   output logic           o_pc_sel,
   output logic           o_acc_en,
   output logic [1:0]     o_alu_op,
   output logic           o_halted,
   output logic [1:0]     o_fault
);

   state_t     r_state, w_next;
   logic [1:0] r_fault, w_fault_set;
   logic       w_expired, w_clear, w_count, w_waiting;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_fault <= 2'b00;
      end else begin
         r_state <= w_next;
         r_fault <= r_fault | w_fault_set;
      end
   end

   // Any state change restarts the count, so each entry into a wait state
   // starts from zero.
   assign w_waiting = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
   assign w_clear   = (w_next != r_state);
   assign w_count   = w_waiting && !i_mem_ready;

   wait_timer #(.CW(CW)) u_timer (
      .clk       (clk),
      .rst       (rst),
      .i_clear   (w_clear),
      .i_count   (w_count),
      .i_limit   (CW'(TIMEOUT)),
      .o_expired (w_expired)
   );

   always_comb begin
      w_next      = r_state;
      w_fault_set = 2'b00;
      o_mem_rd    = 1'b0;
      o_mem_wr    = 1'b0;
      o_addr_sel  = 1'b0;
      o_ir_en     = 1'b0;
      o_pc_en     = 1'b0;
      o_pc_sel    = 1'b0;
      o_acc_en    = 1'b0;
      o_alu_op    = ALU_PASS;
      o_halted    = 1'b0;
      unique case (r_state)
         S_IDLE: w_next = S_FETCH;
         S_FETCH: begin
            o_mem_rd = 1'b1;
            // ready on the last wait cycle still completes normally
            if (i_mem_ready) begin
               o_ir_en = 1'b1;
               o_pc_en = 1'b1;
               w_next  = S_DECODE;
            end else if (w_expired) begin
               w_fault_set[FAULT_TMO] = 1'b1;
               w_next                 = S_HALT;
            end
         end
         S_DECODE: begin
            case (i_opcode)
               OPW'(OP_NOP):   w_next = S_FETCH;
               OPW'(OP_LOAD),
               OPW'(OP_ADD),
               OPW'(OP_SUB):   w_next = S_MEMRD;
               OPW'(OP_STORE): w_next = S_MEMWR;
               OPW'(OP_JMP): begin
                  o_pc_en  = 1'b1;
                  o_pc_sel = 1'b1;
                  w_next   = S_FETCH;
               end
               OPW'(OP_JZ): begin
                  o_pc_en  = i_zero;
                  o_pc_sel = i_zero;
                  w_next   = S_FETCH;
               end
               OPW'(OP_HALT):  w_next = S_HALT;
               default: begin
                  w_fault_set[FAULT_ILL] = 1'b1;
                  w_next                 = S_HALT;
               end
            endcase
         end
         S_MEMRD: begin
            o_mem_rd   = 1'b1;
            o_addr_sel = 1'b1;
            // IR is stable here, so the opcode can drive alu_op directly
            case (i_opcode)
               OPW'(OP_ADD): o_alu_op = ALU_ADD;
               OPW'(OP_SUB): o_alu_op = ALU_SUB;
               default:      o_alu_op = ALU_PASS;
            endcase
            if (i_mem_ready) begin
               o_acc_en = 1'b1;
               w_next   = S_FETCH;
            end else if (w_expired) begin
               w_fault_set[FAULT_TMO] = 1'b1;
               w_next                 = S_HALT;
            end
         end
         S_MEMWR: begin
            o_mem_wr   = 1'b1;
            o_addr_sel = 1'b1;
            if (i_mem_ready) begin
               w_next = S_FETCH;
            end else if (w_expired) begin
               w_fault_set[FAULT_TMO] = 1'b1;
               w_next                 = S_HALT;
            end
         end
         S_HALT:  o_halted = 1'b1;
         default: w_next = S_IDLE;
      endcase
   end

   assign o_fault = r_fault;

endmodule

// File: tb/tb_ctrl_seq.sv
module tb_ctrl_seq;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] opcode = 4'd0;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic       mem_rd, mem_wr, addr_sel, ir_en, pc_en, pc_sel, acc_en, halted;
   logic [1:0] alu_op, fault;

   int n_chk  = 0;
   int n_fail = 0;

   ctrl_seq #(.OPW(4), .TIMEOUT(16), .CW(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .i_opcode    (opcode),
      .i_zero      (zero),
      .i_mem_ready (mem_ready),
      .o_mem_rd    (mem_rd),
      .o_mem_wr    (mem_wr),
      .o_addr_sel  (addr_sel),
      .o_ir_en     (ir_en),
      .o_pc_en     (pc_en),
      .o_pc_sel    (pc_sel),
      .o_acc_en    (acc_en),
      .o_alu_op    (alu_op),
      .o_halted    (halted),
      .o_fault     (fault)
   );

   always #5 clk = ~clk;

   // Observed output vector: {rd, wr, addr_sel, ir, pc, pc_sel, acc, alu[1:0], halted, fault[1:0]}
   logic [11:0] obs;
   assign obs = {mem_rd, mem_wr, addr_sel, ir_en, pc_en, pc_sel, acc_en, alu_op, halted, fault};

   localparam logic [11:0] Z     = 12'h000;
   localparam logic [11:0] L_RD  = 12'h800;
   localparam logic [11:0] L_WR  = 12'h400;
   localparam logic [11:0] L_AS  = 12'h200;
   localparam logic [11:0] L_IR  = 12'h100;
   localparam logic [11:0] L_PC  = 12'h080;
   localparam logic [11:0] L_PS  = 12'h040;
   localparam logic [11:0] L_ACC = 12'h020;
   localparam logic [11:0] L_SUB = 12'h010;
   localparam logic [11:0] L_ADD = 12'h008;
   localparam logic [11:0] L_H   = 12'h004;
   localparam logic [11:0] L_FT  = 12'h002;
   localparam logic [11:0] L_FI  = 12'h001;

   task automatic chk(input string tag, input logic [11:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %b required %b", tag, obs, exp);
      end
   endtask

   // Advance to the next falling edge, apply inputs, let combinational outputs settle.
   task automatic nxt(input logic rdy, input logic [3:0] op, input logic z);
      @(negedge clk);
      mem_ready = rdy;
      opcode    = op;
      zero      = z;
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      mem_ready = 1'b0;
      #1;
      @(negedge clk);
      rst = 1'b0;
      #1;
   endtask

   initial begin
      // reset state
      #1;
      chk("reset_hold", Z);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("idle_after_reset", Z);

      // ADD: fetch ready on first cycle, MEMRD ready on third cycle
      nxt(1'b1, 4'd2, 1'b0); chk("add_fetch", L_RD | L_IR | L_PC);
      nxt(1'b0, 4'd2, 1'b0); chk("add_decode", Z);
      nxt(1'b0, 4'd2, 1'b0); chk("add_memrd1", L_RD | L_AS | L_ADD);
      nxt(1'b0, 4'd2, 1'b0); chk("add_memrd2", L_RD | L_AS | L_ADD);
      nxt(1'b1, 4'd2, 1'b0); chk("add_memrd3", L_RD | L_AS | L_ADD | L_ACC);
      nxt(1'b0, 4'd2, 1'b0); chk("add_back_fetch", L_RD);

      // SUB, then LOAD interrupted by reset mid-handshake
      nxt(1'b1, 4'd3, 1'b0); chk("sub_fetch", L_RD | L_IR | L_PC);
      nxt(1'b0, 4'd3, 1'b0); chk("sub_decode", Z);
      nxt(1'b1, 4'd3, 1'b0); chk("sub_memrd", L_RD | L_AS | L_SUB | L_ACC);
      nxt(1'b1, 4'd1, 1'b0); chk("load_fetch", L_RD | L_IR | L_PC);
      nxt(1'b0, 4'd1, 1'b0); chk("load_decode", Z);
      nxt(1'b0, 4'd1, 1'b0); chk("load_memrd", L_RD | L_AS);
      rst = 1'b1;
      #1;
      chk("async_reset_memrd", Z);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("idle_after_mid_reset", Z);
      nxt(1'b0, 4'd0, 1'b0); chk("fetch_after_mid_reset", L_RD);

      // JZ taken, JZ not taken, JMP
      nxt(1'b1, 4'd6, 1'b1); chk("jz1_fetch", L_RD | L_IR | L_PC);
      nxt(1'b0, 4'd6, 1'b1); chk("jz_taken", L_PC | L_PS);
      nxt(1'b1, 4'd6, 1'b0); chk("jz0_fetch", L_RD | L_IR | L_PC);
      nxt(1'b1, 4'd6, 1'b0); chk("jz_not_taken", Z);
      nxt(1'b1, 4'd5, 1'b0); chk("jmp_fetch", L_RD | L_IR | L_PC);
      nxt(1'b0, 4'd5, 1'b0); chk("jmp_decode", L_PC | L_PS);

      // STORE
      nxt(1'b1, 4'd4, 1'b0); chk("store_fetch", L_RD | L_IR | L_PC);
      nxt(1'b0, 4'd4, 1'b0); chk("store_decode", Z);
      nxt(1'b0, 4'd4, 1'b0); chk("store_memwr_wait", L_WR | L_AS);
      nxt(1'b1, 4'd4, 1'b0); chk("store_memwr_done", L_WR | L_AS);
      nxt(1'b0, 4'd0, 1'b0); chk("store_back_fetch", L_RD);

      // Timeout in MEMRD: 16 wait cycles without ready
      nxt(1'b1, 4'd1, 1'b0); chk("tmo_fetch", L_RD | L_IR | L_PC);
      nxt(1'b0, 4'd1, 1'b0); chk("tmo_decode", Z);
      for (int i = 0; i < 16; i++) begin
         nxt(1'b0, 4'd1, 1'b0); chk($sformatf("tmo_wait%0d", i + 1), L_RD | L_AS);
      end
      nxt(1'b1, 4'd1, 1'b0); chk("tmo_halted", L_H | L_FT);
      nxt(1'b1, 4'd0, 1'b0); chk("tmo_stays_halted", L_H | L_FT);

      // Ready on the 16th FETCH wait cycle wins over timeout
      do_reset();
      chk("idle_second_run", Z);
      for (int i = 0; i < 15; i++) begin
         nxt(1'b0, 4'd0, 1'b0); chk($sformatf("edge_wait%0d", i + 1), L_RD);
      end
      nxt(1'b1, 4'd0, 1'b0); chk("edge_ready16", L_RD | L_IR | L_PC);
      nxt(1'b0, 4'd0, 1'b0); chk("edge_decode_nofault", Z);
      nxt(1'b0, 4'd0, 1'b0); chk("edge_fetch_nofault", L_RD);

      // Illegal opcode 12, then 20 cycles with mem_ready toggling
      nxt(1'b1, 4'd12, 1'b0); chk("ill_fetch", L_RD | L_IR | L_PC);
      nxt(1'b0, 4'd12, 1'b0); chk("ill_decode", Z);
      for (int i = 0; i < 20; i++) begin
         nxt(1'(i % 2), 4'd12, 1'b1); chk($sformatf("ill_halt%0d", i), L_H | L_FI);
      end

      // HALT opcode: clean halt, no fault
      do_reset();
      nxt(1'b1, 4'd7, 1'b0); chk("halt_fetch", L_RD | L_IR | L_PC);
      nxt(1'b0, 4'd7, 1'b0); chk("halt_decode", Z);
      nxt(1'b1, 4'd7, 1'b0); chk("halt_state", L_H);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
